seq_divider_16: RTL

//  Iterative unsigned restoring divider: the inverse arithmetic path to the 16-bit CLA adder.

---
 rtl/seq_divider_16_pkg.sv | 12 +
 rtl/seq_divider_16_trial_subtractor.sv | 33 +++
 rtl/seq_divider_16.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_divider_16_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_divider_16_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_16_trial_subtractor.sv
// Trial subtraction on a carry-lookahead adder: minuend + ~subtrahend + 1.
// borrow is the inverted carry out, so borrow=1 means subtrahend > minuend.
module trial_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N-1:0] difference,
    output logic         borrow
);

    logic [N-1:0] b_op;
    logic [N-1:0] prop;
    logic [N-1:0] gen;
    logic [N:0]   carry;

    assign b_op = ~subtrahend;
    assign prop = minuend ^ b_op;
    assign gen  = minuend & b_op;

    // Carry chain from generate/propagate terms, carry-in tied high for two's complement.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign difference = prop ^ carry[N-1:0];
    assign borrow     = ~carry[N];

endmodule

// File: rtl/seq_divider_16.sv
// Iterative unsigned restoring divider, one quotient bit per clock, behind a start/done handshake.
// Handshake: start is sampled only in IDLE or DONE; done pulses for one cycle in DONE with results valid.
module seq_divider_16
    import seq_divider_16_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output div_state_t       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             borrow;

    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    trial_subtractor #(.N(WIDTH + 1)) u_sub (
        .minuend    (r_shift),
        .subtrahend ({1'b0, d_reg}),
        .difference (r_trial),
        .borrow     (borrow)
    );

    // Restore on borrow: keep the shifted remainder and shift a 0 into the quotient.
    assign r_next    = borrow ? r_shift : r_trial;
    assign q_next    = {q_reg[WIDTH-2:0], ~borrow};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
        end else begin
            case (state)
                DIV_IDLE, DIV_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DIV_DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            state       <= DIV_RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            d_reg       <= divisor;
                            cnt         <= CW'(WIDTH);
                        end
                    end else begin
                        state <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DIV_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
